// File: rtl/mmse_precalc_seq.sv
// mmse_precalc_seq: sequential MMSE pre-calculation, A = H^T*H + snr*I and b = H^T*r,
// built around one shared multiply-accumulate unit.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid / in_ready           input handshake for H_matrix, signal_receive, snr
//   H_matrix[row][col]            channel matrix, DW-bit signed entries
//   signal_receive[k]             received vector, DW-bit signed entries
//   snr                           diagonal loading term
//   out_valid / out_ready         result handshake
//   matrix_A[i][j], vector_b[i]   results, narrowed to DW bits (wrap or saturate)
//   busy                          high while computing A or b
module mmse_precalc_seq #(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned SAT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:N-1][0:N-1][DW-1:0]  H_matrix,
  input  logic [0:N-1][DW-1:0]         signal_receive,
  input  logic [DW-1:0]                snr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:N-1][0:N-1][DW-1:0]  matrix_A,
  output logic [0:N-1][DW-1:0]         vector_b,
  output logic                         busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned AW = PW + $clog2(N) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, DONE} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [AW-1:0]          acc_q, acc_d;
  logic [0:N-1][0:N-1][DW-1:0]   h_q;
  logic [0:N-1][DW-1:0]          r_q;
  logic signed [DW-1:0]          snr_q;
  logic [0:N-1][0:N-1][DW-1:0]   a_q;
  logic [0:N-1][DW-1:0]          b_q;
  logic                          in_ready_q, busy_q, out_valid_q;
  logic                          accept, a_we, b_we;

  logic signed [DW-1:0]          op_x, op_y;
  logic signed [PW-1:0]          prod;
  logic signed [AW-1:0]          acc_sum, a_full;
  logic [DW-1:0]                 a_val, b_val;

  // Narrow a wide accumulator value to DW bits: wrap, or clamp when SAT is set.
  function automatic logic [DW-1:0] narrow(input logic [AW-1:0] v);
    if ((SAT != 0) && (v[AW-1:DW-1] != {(AW-DW+1){v[AW-1]}}))
      return v[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  // Shared MAC: second operand is H[k][j] for A, r[k] for b.
  always_comb begin
    op_x    = h_q[k_q][i_q];
    op_y    = (state_q == CALC_B) ? r_q[k_q] : h_q[k_q][j_q];
    prod    = PW'(op_x) * PW'(op_y);
    acc_sum = acc_q + AW'(prod);
    a_full  = acc_sum + ((i_q == j_q) ? AW'(snr_q) : '0);
    a_val   = narrow(a_full);
    b_val   = narrow(acc_sum);
  end

  // Next-state and sequencing of the i/j/k loop counters.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          accept  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = CALC_A;
        end
      end
      CALC_A: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST) begin
          a_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (j_q == LAST) begin
            if (i_q == LAST) begin
              i_d     = '0;
              j_d     = '0;
              state_d = CALC_B;
            end else begin
              // Upper triangle only: next row starts on the diagonal.
              i_d = i_q + 1'b1;
              j_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      CALC_B: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST) begin
          b_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      h_q         <= '0;
      r_q         <= '0;
      snr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == CALC_A) || (state_d == CALC_B);
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        h_q   <= H_matrix;
        r_q   <= signal_receive;
        snr_q <= snr;
        a_q   <= '0;
        b_q   <= '0;
      end
      // Same value to both mirror positions keeps A exactly symmetric.
      if (a_we) begin
        a_q[i_q][j_q] <= a_val;
        a_q[j_q][i_q] <= a_val;
      end
      if (b_we) b_q[i_q] <= b_val;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign matrix_A  = a_q;
  assign vector_b  = b_q;

endmodule

// File: tb/tb_mmse_precalc_seq.sv
// Testbench for mmse_precalc_seq: directed vectors on N=4/DW=32 (wrap and saturate)
// and N=2/DW=16 builds.
module tb_mmse_precalc_seq;

  typedef logic [0:3][0:3][31:0] m4_t;
  typedef logic [0:3][31:0]      v4_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N=4 wrap and saturate instances share their inputs.
  logic in_valid4, out_ready4;
  m4_t  h4;
  v4_t  r4;
  logic [31:0] snr4;
  logic in_ready4, out_valid4, busy4;
  m4_t  A4;
  v4_t  b4;
  logic in_ready4s, out_valid4s, busy4s;
  m4_t  A4s;
  v4_t  b4s;

  // N=2, DW=16 instance.
  logic in_valid2, out_ready2;
  logic [0:1][0:1][15:0] h2;
  logic [0:1][15:0] r2;
  logic [15:0] snr2;
  logic in_ready2, out_valid2, busy2;
  logic [0:1][0:1][15:0] A2;
  logic [0:1][15:0] b2;

  int vectors = 0;
  int miscompares = 0;

  // Hand-computed H^T*H + 2I and H^T*r for H[r][c] = 4r+c-7, r = [3,-2,0,9].
  int ga [4][4] = '{'{86, 80, 76, 72}, '{80, 82, 80, 80}, '{76, 80, 86, 88}, '{72, 80, 88, 98}};
  int gb [4]    = '{30, 40, 50, 60};

  mmse_precalc_seq #(.N(4), .DW(32), .SAT(0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .H_matrix(h4), .signal_receive(r4), .snr(snr4), .out_valid(out_valid4),
    .out_ready(out_ready4), .matrix_A(A4), .vector_b(b4), .busy(busy4));

  mmse_precalc_seq #(.N(4), .DW(32), .SAT(1)) dut4s (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4s),
    .H_matrix(h4), .signal_receive(r4), .snr(snr4), .out_valid(out_valid4s),
    .out_ready(out_ready4), .matrix_A(A4s), .vector_b(b4s), .busy(busy4s));

  mmse_precalc_seq #(.N(2), .DW(16), .SAT(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .H_matrix(h2), .signal_receive(r2), .snr(snr2), .out_valid(out_valid2),
    .out_ready(out_ready2), .matrix_A(A2), .vector_b(b2), .busy(busy2));

  function automatic m4_t ident_h();
    m4_t h;
    for (int a = 0; a < 4; a++)
      for (int c = 0; c < 4; c++) h[a][c] = (a == c) ? 32'd1 : 32'd0;
    return h;
  endfunction

  function automatic m4_t gen_h();
    m4_t h;
    for (int a = 0; a < 4; a++)
      for (int c = 0; c < 4; c++) h[a][c] = 32'(4 * a + c - 7);
    return h;
  endfunction

  function automatic v4_t seq_r();
    v4_t r;
    for (int a = 0; a < 4; a++) r[a] = 32'(a + 1);
    return r;
  endfunction

  function automatic v4_t gen_r();
    v4_t r;
    r[0] = 32'd3; r[1] = -32'sd2; r[2] = 32'd0; r[3] = 32'd9;
    return r;
  endfunction

  // Drive one input set into the N=4 pair, then garble the inputs after accept.
  // lat is the cycle index (accept edge = 0) at which out_valid is first seen, -1 on timeout.
  task automatic apply4(input m4_t h, input v4_t r, input logic [31:0] s,
                        output int lat, output logic busy1);
    int n;
    h4 = h; r4 = r; snr4 = s; in_valid4 = 1'b1;
    n = 0;
    while (in_ready4 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    for (int a = 0; a < 4; a++) begin
      r4[a] = $urandom();
      for (int c = 0; c < 4; c++) h4[a][c] = $urandom();
    end
    snr4 = $urandom();
    busy1 = busy4;
    lat = 1;
    while (out_valid4 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (out_valid4 !== 1'b1) lat = -1;
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    h4 = ident_h(); r4 = seq_r(); snr4 = 32'd5;
    in_valid4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy=%b vld=%b busy=%b expected 0 0 0", in_ready4, out_valid4, busy4);
    end
    vectors++;
    if (A4 !== '0 || b4 !== '0 || A2 !== '0 || b2 !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero result registers expected all zero");
    end
    in_valid4 = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b busy=%b expected 1 0", in_ready4, busy4);
    end
  endtask

  task automatic test_identity();
    int lat;
    logic b1;
    apply4(ident_h(), seq_r(), 32'd5, lat, b1);
    vectors++;
    if (lat != 57 || b1 !== 1'b1) begin
      miscompares++;
      $display("FAIL identity_latency: got lat=%0d busy1=%b expected 57 1", lat, b1);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (A4[i][j] !== ((i == j) ? 32'd6 : 32'd0)) begin
          miscompares++;
          $display("FAIL identity_A[%0d][%0d]: got %0d expected %0d", i, j, $signed(A4[i][j]), (i == j) ? 6 : 0);
        end
      end
      vectors++;
      if (b4[i] !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL identity_b[%0d]: got %0d expected %0d", i, $signed(b4[i]), i + 1);
      end
    end
    release4();
  endtask

  task automatic test_general();
    int lat;
    logic b1;
    apply4(gen_h(), gen_r(), 32'd2, lat, b1);
    vectors++;
    if (lat != 57) begin
      miscompares++;
      $display("FAIL general_latency: got %0d expected 57", lat);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (A4[i][j] !== 32'(ga[i][j])) begin
          miscompares++;
          $display("FAIL general_A[%0d][%0d]: got %0d expected %0d", i, j, $signed(A4[i][j]), ga[i][j]);
        end
        if (j > i) begin
          vectors++;
          if (A4[i][j] !== A4[j][i]) begin
            miscompares++;
            $display("FAIL general_sym[%0d][%0d]: got %h expected %h", i, j, A4[i][j], A4[j][i]);
          end
        end
      end
      vectors++;
      if (b4[i] !== 32'(gb[i])) begin
        miscompares++;
        $display("FAIL general_b[%0d]: got %0d expected %0d", i, $signed(b4[i]), gb[i]);
      end
    end
    release4();
  endtask

  task automatic test_overflow();
    int lat;
    logic b1;
    m4_t h;
    v4_t r;
    for (int a = 0; a < 4; a++) begin
      r[a] = 32'd1;
      for (int c = 0; c < 4; c++) h[a][c] = 32'h7FFF_FFFF;
    end
    apply4(h, r, 32'd0, lat, b1);
    vectors++;
    if (lat != 57 || out_valid4s !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_latency: got lat=%0d sat_vld=%b expected 57 1", lat, out_valid4s);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (A4[i][j] !== 32'd4) begin
          miscompares++;
          $display("FAIL overflow_wrap_A[%0d][%0d]: got %h expected 00000004", i, j, A4[i][j]);
        end
        vectors++;
        if (A4s[i][j] !== 32'h7FFF_FFFF) begin
          miscompares++;
          $display("FAIL overflow_sat_A[%0d][%0d]: got %h expected 7fffffff", i, j, A4s[i][j]);
        end
      end
      vectors++;
      if (b4[i] !== 32'hFFFF_FFFC || b4s[i] !== 32'h7FFF_FFFF) begin
        miscompares++;
        $display("FAIL overflow_b[%0d]: got wrap=%h sat=%h expected fffffffc 7fffffff", i, b4[i], b4s[i]);
      end
    end
    release4();
  endtask

  task automatic test_backpressure();
    int lat;
    logic b1;
    m4_t sa;
    v4_t sb;
    apply4(ident_h(), seq_r(), 32'd5, lat, b1);
    vectors++;
    if (lat != 57) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d expected 57", lat);
    end
    sa = A4; sb = b4;
    // Second set offered while the first result is still held.
    h4 = gen_h(); r4 = gen_r(); snr4 = 32'd2; in_valid4 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (A4 !== sa || b4 !== sb || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b stable=%b expected 1 0 1", c, out_valid4, in_ready4, (A4 === sa && b4 === sb));
      end
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    vectors++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: got vld=%b rdy=%b busy=%b expected 0 1 0", out_valid4, in_ready4, busy4);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    vectors++;
    if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: got busy=%b rdy=%b expected 1 0", busy4, in_ready4);
    end
    lat = 1;
    while (out_valid4 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (out_valid4 !== 1'b1 || lat != 57) begin
      miscompares++;
      $display("FAIL bp_second_latency: got %0d expected 57", lat);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (A4[i][i] !== 32'(ga[i][i]) || b4[i] !== 32'(gb[i])) begin
        miscompares++;
        $display("FAIL bp_second[%0d]: got A=%0d b=%0d expected %0d %0d", i, $signed(A4[i][i]), $signed(b4[i]), ga[i][i], gb[i]);
      end
    end
    release4();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int lat;
    logic b1;
    h4 = gen_h(); r4 = gen_r(); snr4 = 32'd2; in_valid4 = 1'b1;
    cyc = 0;
    while (in_ready4 !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 1;
    while (cyc < 30) begin @(posedge clk); #1; cyc++; end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b0 || A4 !== '0 || b4 !== '0) begin
      miscompares++;
      $display("FAIL midreset_abort: got vld=%b busy=%b rdy=%b A0=%h expected 0 0 0 0", out_valid4, busy4, in_ready4, A4[0][0]);
    end
    reset = 1'b0;
    apply4(ident_h(), seq_r(), 32'd5, lat, b1);
    vectors++;
    if (lat != 57) begin
      miscompares++;
      $display("FAIL midreset_latency: got %0d expected 57", lat);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (A4[i][i] !== 32'd6 || A4[i][(i + 1) % 4] !== 32'd0 || b4[i] !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL midreset_identity[%0d]: got A=%0d b=%0d expected 6 %0d", i, $signed(A4[i][i]), $signed(b4[i]), i + 1);
      end
    end
    // Reset while results are held in DONE.
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid4 !== 1'b0 || A4 !== '0 || b4 !== '0) begin
      miscompares++;
      $display("FAIL done_reset: got vld=%b A00=%h b0=%h expected 0 0 0", out_valid4, A4[0][0], b4[0]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_n2();
    int n;
    int lat;
    int ea [2][2] = '{'{11, 14}, '{14, 21}};
    int eb [2]    = '{23, 34};
    h2[0][0] = 16'd1; h2[0][1] = 16'd2; h2[1][0] = 16'd3; h2[1][1] = 16'd4;
    r2[0] = 16'd5; r2[1] = 16'd6; snr2 = 16'd1;
    in_valid2 = 1'b1;
    n = 0;
    while (in_ready2 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    h2 = '1; r2 = '1; snr2 = 16'h7777;
    lat = 1;
    while (out_valid2 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (out_valid2 !== 1'b1 || lat != 11) begin
      miscompares++;
      $display("FAIL n2_latency: got %0d expected 11", lat);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        vectors++;
        if (A2[i][j] !== 16'(ea[i][j])) begin
          miscompares++;
          $display("FAIL n2_A[%0d][%0d]: got %0d expected %0d", i, j, $signed(A2[i][j]), ea[i][j]);
        end
      end
      vectors++;
      if (b2[i] !== 16'(eb[i])) begin
        miscompares++;
        $display("FAIL n2_b[%0d]: got %0d expected %0d", i, $signed(b2[i]), eb[i]);
      end
    end
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    vectors++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL n2_release: got vld=%b rdy=%b expected 0 1", out_valid2, in_ready2);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    h4 = '0; r4 = '0; snr4 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    h2 = '0; r2 = '0; snr2 = '0;
    test_reset();
    test_identity();
    test_general();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_n2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmse_precalc_seq.md
# mmse_precalc_seq

Sequential, parametrised MMSE pre-calculation engine. For an N×N real channel matrix H, received vector r and regularisation term snr, it computes A = Hᵀ·H + snr·I and b = Hᵀ·r using one shared multiply-accumulate unit. It replaces the flat combinational pre-calculation stage in front of the linear solver and trades latency for area. Inputs are taken with a valid/ready handshake, and results are held under a valid/ready handshake.

## Interface
- N, default 4: antenna count; matrix dimension, N ≥ 2.
- DW, default 32: signed two's-complement data width of all inputs and outputs.
- SAT, default 0: output narrowing mode. 0 keeps the low DW bits (wrap); 1 saturates to the DW signed range.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input set valid.
- in_ready  out  1  block accepts an input set.
- H_matrix  in  DW×[0:N-1][0:N-1]  channel matrix H[row][col].
- signal_receive  in  DW×[0:N-1]  received vector r.
- snr  in  DW  diagonal loading term.
- out_valid  out  1  results valid and stable.
- out_ready  in  1  consumer accepts results.
- matrix_A  out  DW×[0:N-1][0:N-1]  A result.
- vector_b  out  DW×[0:N-1]  b result.
- busy  out  1  high in CALC_A or CALC_B.

## Operation
- States are IDLE, CALC_A, CALC_B and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready, register H, r and snr.
  - Clear the matrix_A and vector_b registers to 0.
  - Set i = j = k = 0 and the accumulator to 0, then go to CALC_A.
- **CALC_A** (upper triangle only, j = i..N-1)
  - Each cycle computes acc_next = acc + H[k][i]·H[k][j].
  - When k = N-1: form v = acc_next, plus sign-extended snr if i == j.
  - Write narrow(v) to both A[i][j] and A[j][i] in the same cycle, then clear acc and reset k to 0.
  - Then advance j. When j wraps past N-1, do i++ and j = i.
  - After element (N-1, N-1) is written, set i = 0 and go to CALC_B.
- **CALC_B**
  - Each cycle computes acc_next = acc + H[k][i]·r[k].
  - When k = N-1: write b[i] = narrow(acc_next), clear acc and do i++.
  - After b[N-1] is written, go to DONE.
- **DONE**
  - out_valid = 1; matrix_A and vector_b are held unchanged.
  - On out_ready, go to IDLE.
- **Arithmetic**
  - Products are full 2·DW signed.
  - The accumulator is 2·DW + clog2(N) + 1 bits wide, so it never overflows internally.
  - narrow() truncates to DW bits when SAT = 0, and clamps to [−2^(DW−1), 2^(DW−1)−1] when SAT = 1.
- **Exact symmetry**: A[i][j] == A[j][i] bit-for-bit for all i and j.
- **Input stability**: H_matrix, signal_receive and snr are don't-care outside the accept cycle; only the registered copies are used.

## Timing
- **Reset**
  - While reset is high: state = IDLE, out_valid = 0, busy = 0, all matrix_A/vector_b entries = 0, acc = 0 and counters = 0.
  - in_ready = 0 while reset is high and 1 from the first cycle after reset deasserts.
  - in_valid is ignored during reset.
- **Compute length**: C = N·(N(N+1)/2 + N) cycles. N = 4 gives 56; N = 2 gives 10.
- **Latency**
  - The accept edge is cycle 0. busy is high during cycles 1..C.
  - out_valid rises in cycle C+1.
- **Output handshake and throughput**
  - out_valid stays high until the edge where out_ready = 1; the block is in IDLE the next cycle.
  - Minimum input-to-input spacing is C+2 cycles.
  - out_ready is ignored outside DONE.
- **Reset mid-operation**: a reset in CALC_A, CALC_B or DONE aborts with no partial out_valid. All outputs return to 0 and the captured data is discarded.
- **Input during compute**: in_valid asserted during CALC_A, CALC_B or DONE is not accepted (in_ready = 0). The source must hold it until accepted.

## Test plan
- **Identity channel** (N=4): H = I, r = [1, 2, 3, 4], snr = 5.
  - Required: A = 6·I and b = [1, 2, 3, 4].
  - out_valid rises exactly 57 cycles after accept.
- **General channel**: H[r][c] = r·4 + c − 7, r = [3, −2, 0, 9], snr = 2.
  - Required: A and b match the reference model Hᵀ·H + 2I and Hᵀ·r.
  - Required: A is bit-exactly symmetric.
- **Overflow** (N=4): all H entries = 0x7FFFFFFF, snr = 0.
  - SAT=0: every A entry = 4 for the low 32 bits (4·(2^31−1)² mod 2^32).
  - SAT=1: every A entry = 0x7FFFFFFF.
- **Backpressure and overlap**
  - Hold out_ready = 0 for 20 cycles after out_valid: outputs stay stable and in_ready stays 0.
  - Then a one-cycle out_ready: IDLE follows and a second set is accepted in the next cycle.
- **Reset mid-compute**: assert reset at cycle 30 of a run.
  - Required: next cycle all outputs = 0 and out_valid = 0.
  - A fresh identity test then passes with the normal latency.
- **N=2, DW=16 build**: H = [[1, 2], [3, 4]], r = [5, 6], snr = 1.
  - Required: A = [[11, 14], [14, 21]] and b = [23, 34].
  - out_valid rises at cycle 11.
